// File: rtl/fetch_redirect_ctrl.sv
// Fetch PC owner: applies branch redirects, holds them across stalls, kills wrong path.
// Optional taken-redirect counter enabled by defining BRANCH_STATS_EN.
module fetch_redirect_ctrl #(
    parameter int              PC_W     = 9,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            stall_i,
    input  logic            PcSel,
    input  logic [31:0]     BrPC,
    input  logic            halt_i,
    output logic [PC_W-1:0] pc_o,
    output logic            if_valid_o,
    output logic            flush_ifid_o,
    output logic            flush_idex_o,
    output logic            halted_o,
    output logic            misalign_o,
    output logic [15:0]     redirect_cnt_o
);

    typedef enum logic [1:0] {RUN, BUBBLE, HALTED} state_e;

    state_e          state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic [PC_W-1:0] pend_q, pend_d;
    logic [PC_W-1:0] tgt;
    logic            pend_vld_q, pend_vld_d;
    logic            valid_q, valid_d;
    logic            halted_q, halted_d;
    logic            mis_q, mis_d;
    logic            apply;
    logic            unused_hi;

    assign unused_hi = ^BrPC[31:PC_W];

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        pend_d     = pend_q;
        pend_vld_d = pend_vld_q;
        valid_d    = valid_q;
        halted_d   = halted_q;
        mis_d      = 1'b0;
        apply      = 1'b0;
        tgt        = pend_q;
        if (state_q != HALTED) begin
            if (halt_i) begin
                state_d    = HALTED;
                halted_d   = 1'b1;
                valid_d    = 1'b0;
                pend_vld_d = 1'b0;
            end else begin
                // A live redirect supersedes any older pending target
                if (PcSel && !stall_i) begin
                    apply = 1'b1;
                    tgt   = BrPC[PC_W-1:0];
                end else if (!stall_i && pend_vld_q) begin
                    apply = 1'b1;
                end
                if (PcSel && stall_i) begin
                    pend_vld_d = 1'b1;
                    pend_d     = BrPC[PC_W-1:0];
                end
                if (apply) begin
                    pc_d       = {tgt[PC_W-1:2], 2'b00};
                    state_d    = BUBBLE;
                    valid_d    = 1'b0;
                    pend_vld_d = 1'b0;
                    mis_d      = |tgt[1:0];
                end else if (state_q == BUBBLE) begin
                    state_d = RUN;
                    valid_d = 1'b1;
                end else if (!stall_i) begin
                    // First fetch after reset is not advanced past
                    if (valid_q) pc_d = pc_q + PC_W'(3'd4);
                    valid_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= RUN;
            pc_q       <= RESET_PC;
            pend_q     <= '0;
            pend_vld_q <= 1'b0;
            valid_q    <= 1'b0;
            halted_q   <= 1'b0;
            mis_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            pend_q     <= pend_d;
            pend_vld_q <= pend_vld_d;
            valid_q    <= valid_d;
            halted_q   <= halted_d;
            mis_q      <= mis_d;
        end
    end

    assign pc_o         = pc_q;
    assign if_valid_o   = valid_q;
    assign halted_o     = halted_q;
    assign misalign_o   = mis_q;
    assign flush_ifid_o = PcSel && !reset && (state_q != HALTED);
    assign flush_idex_o = flush_ifid_o;

`ifdef BRANCH_STATS_EN
    logic [15:0] cnt_q;

    always_ff @(posedge clk) begin
        if (reset)
            cnt_q <= '0;
        else if (apply && cnt_q != 16'hFFFF)
            cnt_q <= cnt_q + 16'd1;
    end

    assign redirect_cnt_o = cnt_q;
`else
    assign redirect_cnt_o = '0;
`endif

endmodule

// File: tb/tb_fetch_redirect_ctrl.sv
// Scoreboard bench for fetch_redirect_ctrl: directed test-plan sequences plus
// random traffic compared against a behavioural model.
module tb_fetch_redirect_ctrl;

    localparam int PC_W = 9;
    localparam int MOD  = 512;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic            stall_i = 1'b0;
    logic            PcSel = 1'b0;
    logic [31:0]     BrPC = '0;
    logic            halt_i = 1'b0;
    logic [PC_W-1:0] pc_o;
    logic            if_valid_o;
    logic            flush_ifid_o;
    logic            flush_idex_o;
    logic            halted_o;
    logic            misalign_o;
    logic [15:0]     redirect_cnt_o;

    fetch_redirect_ctrl #(.PC_W(PC_W), .RESET_PC('0)) dut (
        .clk(clk), .reset(reset), .stall_i(stall_i), .PcSel(PcSel),
        .BrPC(BrPC), .halt_i(halt_i), .pc_o(pc_o),
        .if_valid_o(if_valid_o), .flush_ifid_o(flush_ifid_o),
        .flush_idex_o(flush_idex_o), .halted_o(halted_o),
        .misalign_o(misalign_o), .redirect_cnt_o(redirect_cnt_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        int unsigned pc;
        bit          v;
        bit          h;
        bit          m;
        int unsigned c;
    } exp_t;

    exp_t exp_q[$];
    bit   flush_q[$];
    int   total = 0;
    int   bad = 0;

    // Behavioural model; mode 0=fetching, 1=waiting one cycle on a new target, 2=halted
    int unsigned m_pc = 0, m_pend = 0, m_cnt = 0;
    int          m_mode = 0;
    bit          m_pv = 0, m_val = 0, m_halt = 0, m_mis = 0;

    task automatic model(input bit rst, input bit st, input bit ps,
                         input logic [31:0] br, input bit hl);
        int unsigned tgt;
        bit apply;
        if (rst) begin
            m_mode = 0; m_pc = 0; m_val = 0; m_halt = 0;
            m_mis = 0; m_pv = 0; m_cnt = 0;
            return;
        end
        m_mis = 0;
        if (m_mode == 2) return;
        if (hl) begin
            m_mode = 2; m_halt = 1; m_val = 0; m_pv = 0;
            return;
        end
        apply = 0;
        tgt = 0;
        if (ps && !st) begin
            apply = 1; tgt = br % MOD;
        end else if (!st && m_pv) begin
            apply = 1; tgt = m_pend;
        end
        if (ps && st) begin
            m_pv = 1; m_pend = br % MOD;
        end
        if (apply) begin
            m_pc = tgt - (tgt % 4);
            m_mis = (tgt % 4) != 0;
            m_mode = 1; m_val = 0; m_pv = 0;
`ifdef BRANCH_STATS_EN
            if (m_cnt < 65535) m_cnt = m_cnt + 1;
`endif
        end else if (m_mode == 1) begin
            m_mode = 0; m_val = 1;
        end else if (!st) begin
            if (m_val) m_pc = (m_pc + 4) % MOD;
            m_val = 1;
        end
    endtask

    task automatic step(input bit rst, input bit st, input bit ps,
                        input logic [31:0] br, input bit hl);
        exp_t e;
        @(negedge clk);
        reset = rst; stall_i = st; PcSel = ps; BrPC = br; halt_i = hl;
        #1;
        flush_q.push_back(ps && !rst && m_mode != 2);
        @(posedge clk);
        model(rst, st, ps, br, hl);
        e.pc = m_pc; e.v = m_val; e.h = m_halt; e.m = m_mis; e.c = m_cnt;
        exp_q.push_back(e);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 32'h0, 0);
    endtask

    initial begin : mon_regs
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                total++;
                if (pc_o != e.pc[PC_W-1:0] || if_valid_o != e.v ||
                    halted_o != e.h || misalign_o != e.m ||
                    redirect_cnt_o != e.c[15:0]) begin
                    bad++;
                    $display("FAIL regs t=%0t: got pc=%h v=%b h=%b m=%b c=%0d want pc=%h v=%b h=%b m=%b c=%0d",
                             $time, pc_o, if_valid_o, halted_o, misalign_o,
                             redirect_cnt_o, e.pc[PC_W-1:0], e.v, e.h, e.m, e.c);
                end
            end
        end
    end

    initial begin : mon_flush
        bit f;
        forever begin
            @(negedge clk);
            #2;
            if (flush_q.size() != 0) begin
                f = flush_q.pop_front();
                total++;
                if (flush_ifid_o != f || flush_idex_o != f) begin
                    bad++;
                    $display("FAIL flush t=%0t: got ifid=%b idex=%b want %b",
                             $time, flush_ifid_o, flush_idex_o, f);
                end
            end
        end
    end

    initial begin
        bit rst, st, ps, hl;
        logic [31:0] br;
        step(1, 0, 0, 32'h0, 0);
        step(1, 1, 1, 32'h44, 0);
        idle(5);
        step(0, 0, 1, 32'h10, 0);
        idle(1);
        step(0, 0, 1, 32'h40, 0);
        idle(3);
        step(0, 0, 1, 32'hFFFF_FE44, 0);
        idle(2);
        step(0, 0, 1, 32'h1F8, 0);
        idle(4);
        step(0, 1, 1, 32'h80, 0);
        step(0, 1, 0, 32'h0, 0);
        step(0, 1, 0, 32'h0, 0);
        idle(3);
        step(0, 1, 1, 32'h100, 0);
        step(0, 0, 1, 32'h120, 0);
        idle(2);
        step(0, 0, 1, 32'h23, 0);
        idle(3);
        step(0, 0, 1, 32'h30, 0);
        idle(2);
        step(0, 0, 1, 32'h60, 1);
        step(0, 1, 1, 32'h90, 0);
        step(0, 0, 1, 32'h94, 0);
        step(0, 0, 0, 32'h0, 1);
        step(1, 0, 1, 32'h98, 1);
        idle(3);
        for (int i = 0; i < 500; i++) begin
            rst = (m_mode == 2 && $urandom_range(3) == 0) ||
                  $urandom_range(199) == 0;
            st  = $urandom_range(3) == 0;
            ps  = $urandom_range(5) == 0;
            hl  = $urandom_range(79) == 0;
            br  = $urandom;
            step(rst, st, ps, br, hl);
        end
        idle(2);
        repeat (2) @(posedge clk);
        #3;
        total++;
        if (exp_q.size() != 0 || flush_q.size() != 0) begin
            bad++;
            $display("FAIL drain: got %0d/%0d pending, want 0/0",
                     exp_q.size(), flush_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fetch_redirect_ctrl.md
Name: fetch_redirect_ctrl

Overview:
- Consumer end of the branch-resolution interface. Accepts the taken/not-taken select and target PC from the branch unit in execute. Owns the fetch PC register.
- Applies redirects, holds them across hazard stalls, and kills wrong-path instructions in IF/ID and ID/EX.
- Sits between the branch unit and instruction memory. Its output PC drives the imem read address.

Parameters:
- PC_W, 9, width of fetch PC and imem byte address
- RESET_PC, 0, PC value loaded on reset (PC_W bits)

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  synchronous, active-high reset
- stall_i  input  1  hazard unit freezes fetch and IF/ID this cycle
- PcSel  input  1  branch/jump taken in execute this cycle
- BrPC  input  32  redirect target from branch unit; valid only when PcSel=1
- halt_i  input  1  halt instruction decoded; stop fetching permanently until reset
- pc_o  output  PC_W  current fetch address to imem
- if_valid_o  output  1  instruction at pc_o is on the correct path and may enter IF/ID
- flush_ifid_o  output  1  kill IF/ID contents at the next edge
- flush_idex_o  output  1  kill ID/EX contents at the next edge
- halted_o  output  1  controller is in HALTED
- misalign_o  output  1  one-cycle pulse: last applied target had BrPC[1:0]!=0
- redirect_cnt_o  output  16  taken-redirect count (only with BRANCH_STATS_EN)

Behaviour:
- States: RUN, BUBBLE, HALTED. State and all outputs are registered except the flush outputs.
- Reset (sync, high): state=RUN, pc_o=RESET_PC, if_valid_o=0, halted_o=0, misalign_o=0, pending=0, flush outputs=0, redirect_cnt_o=0. Reset overrides every other input, including mid-stall, mid-bubble and HALTED.
- Cycle after reset release: if_valid_o=1.
- RUN, stall_i=0, PcSel=0, pending=0: pc_o <= pc_o+4, modulo 2^PC_W (wraps to 0).
- RUN, stall_i=1: pc_o and if_valid_o hold.
- Redirect accept (PcSel=1, not HALTED):
  - flush_ifid_o=1 and flush_idex_o=1 combinationally in the same cycle, regardless of stall_i.
  - If stall_i=0: pc_o <= {BrPC[PC_W-1:2],2'b00}; state <= BUBBLE; if_valid_o <= 0.
  - If stall_i=1: target latched into pending register; a later PcSel while pending overwrites it; pc_o holds.
- Pending apply: the first cycle with stall_i=0 and pending=1 applies the pending target exactly like an unstalled redirect (BUBBLE, if_valid_o=0) and clears pending. PcSel=1 in that same cycle takes priority over pending.
- BUBBLE: exactly one cycle (covers synchronous imem read latency). pc_o holds. Next state RUN with if_valid_o=1. PcSel in BUBBLE is accepted as a normal redirect.
- Target width: BrPC[31:PC_W] are ignored (truncated).
- Misalignment: if BrPC[1:0]!=0 on an applied target, low bits are forced to 0 and misalign_o pulses for 1 cycle on the cycle after apply.
- halt_i=1 (any state except reset):
  - state <= HALTED; halted_o <= 1; if_valid_o <= 0; pc_o frozen; pending cleared.
  - halt_i beats PcSel in the same cycle; flush outputs still assert for that PcSel.
  - HALTED ignores stall_i and PcSel; flush outputs stay 0. Exit only via reset.
- stall_i and PcSel do not affect halt priority.

Optional Feature:
- Macro BRANCH_STATS_EN.
- Defined: redirect_cnt_o increments by 1 on every applied redirect (direct or pending). Saturates at 16'hFFFF. Cleared by reset.
- Undefined: redirect_cnt_o is tied to 0 and the counter logic is not synthesized.

Test Plan:
- Reset release, no stalls, 4 cycles -> pc_o = 0,4,8,12; if_valid_o=1 from the first post-reset cycle.
- pc_o=0x1FC, PC_W=9, advance -> pc_o=0x000 (wrap).
- PcSel=1, BrPC=0x40, stall_i=0 at pc_o=0x10 -> flush_ifid_o=flush_idex_o=1 that cycle; next pc_o=0x40 with if_valid_o=0; following cycle if_valid_o=1, then pc_o=0x44.
- stall_i=1 for 3 cycles; PcSel=1, BrPC=0x80 in the first stalled cycle -> pc_o unchanged during stall; the cycle stall_i drops, pc_o <= 0x80 and a bubble follows; redirect_cnt_o +1 if BRANCH_STATS_EN.
- PcSel=1, BrPC=0x23 -> pc_o=0x20; misalign_o=1 for exactly one cycle.
- halt_i=1 with PcSel=1, BrPC=0x60 at pc_o=0x30 -> pc_o stays 0x30, halted_o=1, if_valid_o=0 forever; then reset -> pc_o=RESET_PC, halted_o=0.
